// File: rtl/pipeline_hazard_controller.sv
// rtl/pipeline_hazard_controller.sv - load-use/branch/memory-stall hazard control and EX operand forwarding
// Mealy enables with priority memBusy > branch > load-use; sticky timeout error after a long memory stall.
`timescale 1ns/1ps

module pipeline_hazard_controller #(
   parameter int MEM_TIMEOUT   = 64,
   parameter int COUNTER_WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [4:0]               idRs1,
   input  logic [4:0]               idRs2,
   input  logic [4:0]               exRs1,
   input  logic [4:0]               exRs2,
   input  logic [4:0]               exRd,
   input  logic                     exIsRegisterWrite,
   input  logic                     exShouldUseMemoryData,
   input  logic                     exBranchTaken,
   input  logic [4:0]               memRd,
   input  logic                     memIsRegisterWrite,
   input  logic [4:0]               wbRd,
   input  logic                     wbIsRegisterWrite,
   input  logic                     memBusy,
   output logic                     pcWrite,
   output logic                     ifIdWrite,
   output logic                     ifIdFlush,
   output logic                     idExWrite,
   output logic                     idExBubble,
   output logic [1:0]               forwardLHS,
   output logic [1:0]               forwardRHS,
   output logic                     memTimeoutError,
   output logic [COUNTER_WIDTH-1:0] stallCycles
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ERROR    = 2'd2
   } state_t;

   localparam logic [7:0] TIMEOUT_LIMIT = 8'(MEM_TIMEOUT);

   state_t                   state_q, state_d;
   logic [7:0]               wait_count_q, wait_count_d;
   logic [COUNTER_WIDTH-1:0] stall_cycles_q, stall_cycles_d;
   logic                     timeout_err_q, timeout_err_d;
   logic                     load_use;

   assign load_use = exShouldUseMemoryData & exIsRegisterWrite & (exRd != 5'd0) &
                     ((idRs1 == exRd) | (idRs2 == exRd));

   always_comb begin
      state_d      = state_q;
      wait_count_d = wait_count_q;
      timeout_err_d = timeout_err_q;
      pcWrite      = 1'b1;
      ifIdWrite    = 1'b1;
      ifIdFlush    = 1'b0;
      idExWrite    = 1'b1;
      idExBubble   = 1'b0;

      case (state_q)
         RUN, MEM_WAIT: begin
            if (memBusy) begin
               pcWrite   = 1'b0;
               ifIdWrite = 1'b0;
               idExWrite = 1'b0;
               if (wait_count_q == TIMEOUT_LIMIT) begin
                  state_d       = ERROR;
                  timeout_err_d = 1'b1;
               end else if (state_q == RUN) begin
                  state_d      = MEM_WAIT;
                  wait_count_d = 8'd1;
               end else begin
                  wait_count_d = wait_count_q + 8'd1;
               end
            end else begin
               state_d      = RUN;
               wait_count_d = 8'd0;
               if (exBranchTaken) begin
                  ifIdFlush  = 1'b1;
                  idExBubble = 1'b1;
               end else if (load_use) begin
                  // One bubble suffices: the load leaves EX on the next edge.
                  pcWrite    = 1'b0;
                  ifIdWrite  = 1'b0;
                  idExBubble = 1'b1;
               end
            end
         end
         ERROR: begin
            pcWrite   = 1'b0;
            ifIdWrite = 1'b0;
            idExWrite = 1'b0;
         end
         default: begin
            state_d = RUN;
         end
      endcase

      if (reset) begin
         pcWrite    = 1'b0;
         ifIdWrite  = 1'b0;
         idExWrite  = 1'b0;
         ifIdFlush  = 1'b1;
         idExBubble = 1'b1;
      end

      stall_cycles_d = stall_cycles_q;
      if (!pcWrite && (stall_cycles_q != {COUNTER_WIDTH{1'b1}})) begin
         stall_cycles_d = stall_cycles_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= RUN;
         wait_count_q   <= 8'd0;
         stall_cycles_q <= '0;
         timeout_err_q  <= 1'b0;
      end else begin
         state_q        <= state_d;
         wait_count_q   <= wait_count_d;
         stall_cycles_q <= stall_cycles_d;
         timeout_err_q  <= timeout_err_d;
      end
   end

   // MEM result is newer than WB, so it wins when both match.
   always_comb begin
      forwardLHS = 2'b00;
      forwardRHS = 2'b00;
      if (memIsRegisterWrite && (memRd != 5'd0) && (memRd == exRs1)) begin
         forwardLHS = 2'b10;
      end else if (wbIsRegisterWrite && (wbRd != 5'd0) && (wbRd == exRs1)) begin
         forwardLHS = 2'b01;
      end
      if (memIsRegisterWrite && (memRd != 5'd0) && (memRd == exRs2)) begin
         forwardRHS = 2'b10;
      end else if (wbIsRegisterWrite && (wbRd != 5'd0) && (wbRd == exRs2)) begin
         forwardRHS = 2'b01;
      end
   end

   assign memTimeoutError = timeout_err_q;
   assign stallCycles     = stall_cycles_q;

endmodule
